// File: rtl/spi_cfg_arbiter.sv
// Two-requester SPI register-write master: arbitrates, then shifts {1'b1, addr[6:0], data[7:0]} MSB first.
// Define SPI_CFG_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module spi_cfg_arbiter #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [4:0] BITS     = 5'd16;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] shift_q, shift_nxt;
  logic [7:0]  cnt_q, cnt_nxt;
  logic [4:0]  bit_q, bit_nxt;
  logic        sclk_q, sclk_nxt;
  logic        grant_q, grant_nxt;
  logic        win;
  logic        any_req;
  logic        cnt_end;

  assign any_req = req0_valid | req1_valid;

`ifdef SPI_CFG_RR_EN
  logic last_q;

  // Reset value 1 makes requester 0 the first winner of a tie.
  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b1;
    else if (state == IDLE && any_req)
      last_q <= win;
  end

  assign win = (req0_valid && req1_valid) ? ~last_q : req1_valid;
`else
  assign win = req1_valid & ~req0_valid;
`endif

  assign cnt_end = (state == GAP) ? (cnt_q == GAP_LAST) : (cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      cnt_q   <= cnt_nxt;
      bit_q   <= bit_nxt;
      sclk_q  <= sclk_nxt;
      grant_q <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_q;
    cnt_nxt    = cnt_end ? 8'd0 : cnt_q + 8'd1;
    bit_nxt    = bit_q;
    sclk_nxt   = sclk_q;
    grant_nxt  = grant_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        // Ready is combinational in IDLE and masked while reset is asserted.
        if (any_req && !rst) begin
          req0_ready = ~win;
          req1_ready = win;
          grant_nxt  = win;
          shift_nxt  = win ? {1'b1, req1_addr, req1_data} : {1'b1, req0_addr, req0_data};
          state_nxt  = SETUP;
        end
      end
      SETUP: if (cnt_end) state_nxt = SHIFT;
      SHIFT: begin
        if (cnt_end && bit_q != BITS) begin
          sclk_nxt = ~sclk_q;
          // Falling edge: advance COPI and count the completed bit.
          if (sclk_q) begin
            shift_nxt = {shift_q[14:0], 1'b0};
            bit_nxt   = bit_q + 5'd1;
            if (bit_q == BITS - 5'd1) state_nxt = HOLD;
          end
        end
      end
      HOLD: if (cnt_end) state_nxt = GAP;
      GAP:  if (cnt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Between back-to-back frames nCS stays high for the GAP cycles plus the IDLE accept cycle.
  assign nCS        = !(state == SETUP || state == SHIFT || state == HOLD);
  assign SCLK       = sclk_q;
  assign COPI       = nCS ? 1'b0 : shift_q[15];
  assign busy       = (state != IDLE);
  assign grant_id   = grant_q;
  assign frame_done = (state == GAP) && (cnt_q == 8'd0);

endmodule
